// File: rtl/scaler_pkg.sv
// Shared types and width helpers for the 1-D scaling sequencer.
package scaler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StInit,
    StRun
  } state_e;

  // Defaults for the reference configuration.
  localparam int unsigned DefSWidth = 12;
  localparam int unsigned DefFBits  = 8;

  // DDA step carries the source count plus the phase fraction.
  function automatic int unsigned step_width(input int unsigned s_w, input int unsigned f_b);
    return s_w + f_b;
  endfunction

  // Position is signed: the centred mapping starts slightly below zero.
  function automatic int unsigned pos_width(input int unsigned s_w, input int unsigned f_b);
    return s_w + f_b + 1;
  endfunction

  function automatic int unsigned bid_width(input int unsigned bufs);
    return (bufs > 1) ? $clog2(bufs) : 1;
  endfunction

endpackage

// File: rtl/scaler_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, DividendW cycles after start_i.
// done_o is high for exactly one cycle; quotient_o holds until the next start_i.
module scaler_serial_div #(
  parameter int unsigned DividendW = 20,
  parameter int unsigned DivisorW  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [DividendW-1:0] dividend_i,
  input  logic [DivisorW-1:0]  divisor_i,
  output logic [DividendW-1:0] quotient_o,
  output logic                 done_o
);

  localparam int unsigned CntW = $clog2(DividendW + 1);

  // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  logic [DividendW-1:0] quo_q, quo_d;
  logic [DivisorW-1:0]  rem_q, rem_d, dvs_q, dvs_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic [DivisorW:0]    rem_sh;

  // One restoring step per cycle while running.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    rem_sh = {rem_q, quo_q[DividendW-1]};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = CntW'(DividendW);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = DivisorW'(rem_sh - {1'b0, dvs_q});
          quo_d = {quo_q[DividendW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DivisorW-1:0];
          quo_d = {quo_q[DividendW-2:0], 1'b0};
        end
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = run_q && (cnt_q == '0);

endmodule

// File: rtl/scaler_phase_gen.sv
// 1-D scaling sequencer: maps output sample index to source index, phase, tap
// advance and per-tap line-buffer id, presented on a valid/ready beat stream.
// Optional SCALER_NEAREST_EN adds a 'nearest' input selecting rounded
// nearest-neighbour mapping for the line.
module scaler_phase_gen
  import scaler_pkg::*;
#(
  parameter int unsigned C_S_WIDTH = 12,
  parameter int unsigned C_M_WIDTH = 12,
  parameter int unsigned C_F_BITS  = 8,
  parameter int unsigned C_TAPS    = 2,
  parameter int unsigned C_S_BUFS  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
`ifdef SCALER_NEAREST_EN
  input  logic                                   nearest,
`endif
  input  logic [C_S_WIDTH-1:0]                   s_nbr,
  input  logic [C_M_WIDTH-1:0]                   m_nbr,
  output logic                                   busy,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [C_S_WIDTH-1:0]                   m_sidx,
  output logic [C_F_BITS-1:0]                    m_phase,
  output logic [C_S_WIDTH-1:0]                   m_sadv,
  output logic [C_TAPS*bid_width(C_S_BUFS)-1:0]  m_bid,
  output logic                                   m_first,
  output logic                                   m_last
);

  localparam int unsigned StepW = step_width(C_S_WIDTH, C_F_BITS);
  localparam int unsigned PosW  = pos_width(C_S_WIDTH, C_F_BITS);
  localparam int unsigned BidW  = bid_width(C_S_BUFS);
  localparam int unsigned IdxW  = C_S_WIDTH + 1;
  localparam logic signed [PosW-1:0] HalfP = PosW'(1) << (C_F_BITS - 1);
  localparam logic signed [PosW:0]   HalfT = (PosW + 1)'(1) << (C_F_BITS - 1);

  state_e                  state_q, state_d;
  logic [C_S_WIDTH-1:0]    s_q, s_d, prev_lim_q, prev_lim_d;
  logic [C_M_WIDTH-1:0]    m_q, m_d, cnt_q, cnt_d;
  logic signed [PosW-1:0]  pos_q, pos_d;
  logic [BidW-1:0]         base_q, base_d;

  logic                    accept, hs, div_done, near_mode;
  logic [StepW-1:0]        step;

  assign accept = start && (state_q == StIdle);
  assign hs     = m_valid && m_ready;

  scaler_serial_div #(
    .DividendW (StepW),
    .DivisorW  (C_M_WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (accept),
    .dividend_i ({s_nbr, {C_F_BITS{1'b0}}}),
    .divisor_i  (m_nbr),
    .quotient_o (step),
    .done_o     (div_done)
  );

`ifdef SCALER_NEAREST_EN
  logic nearest_q, nearest_d;

  // Mapping mode is frozen for the whole line at the accepted start.
  always_comb nearest_d = accept ? nearest : nearest_q;

  // Mode register.
  always_ff @(posedge clk) begin
    if (reset) nearest_q <= 1'b0;
    else       nearest_q <= nearest_d;
  end

  assign near_mode = nearest_q;
`else
  assign near_mode = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDiv;
      StDiv:   if (div_done) state_d = StInit;
      StInit:  state_d = StRun;
      StRun:   if (hs && m_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic signed [PosW:0]   tgt, raw, s_last;
  logic [C_S_WIDTH-1:0]   s_m1, sidx, sadv;
  logic [C_F_BITS-1:0]    phase;
  logic [IdxW-1:0]        lim, tidx;
  logic [C_TAPS*BidW-1:0] bid;

  // Beat decode from the current DDA position.
  always_comb begin
    s_m1   = s_q - C_S_WIDTH'(1);
    s_last = $signed({{(PosW + 1 - C_S_WIDTH){1'b0}}, s_m1});
    tgt    = {pos_q[PosW-1], pos_q};
    if (near_mode) tgt = tgt + HalfT;
    raw   = tgt >>> C_F_BITS;
    sidx  = '0;
    phase = '0;
    if (tgt[PosW]) begin
      sidx = '0;
    end else if (raw >= s_last) begin
      sidx = s_m1;
    end else begin
      sidx  = raw[C_S_WIDTH-1:0];
      phase = near_mode ? '0 : pos_q[C_F_BITS-1:0];
    end
    // Samples needed so far is the clamped end of the tap window.
    lim = {1'b0, sidx} + IdxW'(C_TAPS);
    if (lim > {1'b0, s_q}) lim = {1'b0, s_q};
    sadv = lim[C_S_WIDTH-1:0];
    if (cnt_q != '0) sadv = sadv - prev_lim_q;
    bid  = '0;
    tidx = '0;
    for (int t = 0; t < C_TAPS; t++) begin
      tidx = {1'b0, sidx} + IdxW'(t);
      if (near_mode)                   tidx = {1'b0, sidx};
      else if (tidx > {1'b0, s_m1})    tidx = {1'b0, s_m1};
      bid[t*BidW +: BidW] = BidW'((tidx + IdxW'(base_q)) % IdxW'(C_S_BUFS));
    end
  end

  // Datapath next state: line latch, DDA init/advance, buffer ring base.
  always_comb begin
    s_d        = s_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    prev_lim_d = prev_lim_q;
    base_d     = base_q;
    if (accept) begin
      s_d = s_nbr;
      m_d = m_nbr;
    end
    if (state_q == StInit) begin
      pos_d = $signed(PosW'(step >> 1)) - HalfP;
      cnt_d = '0;
    end
    if (hs) begin
      if (m_last) begin
        base_d = BidW'((IdxW'(base_q) + IdxW'(s_q)) % IdxW'(C_S_BUFS));
      end else begin
        pos_d      = pos_q + $signed(PosW'(step));
        cnt_d      = cnt_q + C_M_WIDTH'(1);
        prev_lim_d = lim[C_S_WIDTH-1:0];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      pos_q      <= '0;
      prev_lim_q <= '0;
      base_q     <= '0;
    end else begin
      s_q        <= s_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      prev_lim_q <= prev_lim_d;
      base_q     <= base_d;
    end
  end

  // Outputs: beat fields are forced to zero outside RUN.
  always_comb begin
    busy    = (state_q != StIdle);
    m_valid = (state_q == StRun);
    m_sidx  = '0;
    m_phase = '0;
    m_sadv  = '0;
    m_bid   = '0;
    m_first = 1'b0;
    m_last  = 1'b0;
    if (state_q == StRun) begin
      m_sidx  = sidx;
      m_phase = phase;
      m_sadv  = sadv;
      m_bid   = bid;
      m_first = (cnt_q == '0);
      m_last  = (cnt_q == m_q - C_M_WIDTH'(1));
    end
  end

endmodule

// File: tb/tb_scaler_phase_gen.sv
// Self-checking bench for scaler_phase_gen (default build, nearest mode off).
module tb_scaler_phase_gen;

  localparam int SW   = 12;
  localparam int MW   = 12;
  localparam int FB   = 8;
  localparam int TAPS = 2;
  localparam int BUFS = 4;
  localparam int LAT  = SW + FB + 2;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [SW-1:0] s_nbr;
  logic [MW-1:0] m_nbr;
  logic          busy, m_valid, m_first, m_last;
  logic [SW-1:0] m_sidx, m_sadv;
  logic [FB-1:0] m_phase;
  logic [3:0]    m_bid;

  scaler_phase_gen #(
    .C_S_WIDTH (SW),
    .C_M_WIDTH (MW),
    .C_F_BITS  (FB),
    .C_TAPS    (TAPS),
    .C_S_BUFS  (BUFS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s_nbr   (s_nbr),
    .m_nbr   (m_nbr),
    .busy    (busy),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sidx  (m_sidx),
    .m_phase (m_phase),
    .m_sadv  (m_sadv),
    .m_bid   (m_bid),
    .m_first (m_first),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] sidx;
    logic [7:0]  phase;
    logic [11:0] sadv;
    logic [3:0]  bid;
    logic        first;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    tb_base = 0;

  // Reference model: push every expected beat of a line.
  function automatic void push_line(input int s, input int m);
    int    step, pos, sidx, ph, lim, prev_lim, idx;
    beat_t b;
    step     = (s * (1 << FB)) / m;
    pos      = step / 2 - (1 << (FB - 1));
    prev_lim = 0;
    for (int k = 0; k < m; k++) begin
      if (pos < 0) begin
        sidx = 0; ph = 0;
      end else if ((pos / (1 << FB)) >= s - 1) begin
        sidx = s - 1; ph = 0;
      end else begin
        sidx = pos / (1 << FB); ph = pos % (1 << FB);
      end
      lim     = (sidx + TAPS < s) ? sidx + TAPS : s;
      b.sidx  = 12'(sidx);
      b.phase = 8'(ph);
      b.sadv  = 12'(lim - prev_lim);
      b.bid   = '0;
      for (int t = 0; t < TAPS; t++) begin
        idx = (sidx + t < s - 1) ? sidx + t : s - 1;
        b.bid[t*2 +: 2] = 2'((tb_base + idx) % BUFS);
      end
      b.first = (k == 0);
      b.last  = (k == m - 1);
      exp_q.push_back(b);
      prev_lim = lim;
      pos      = pos + step;
    end
    tb_base = (tb_base + s) % BUFS;
  endfunction

  // Advance one cycle; a beat seen with valid&ready is scored against the queue.
  task automatic tick();
    beat_t got, exp;
    @(negedge clk);
    if (!reset && m_valid && m_ready) begin
      got = {m_sidx, m_phase, m_sadv, m_bid, m_first, m_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra: got sidx=%0d phase=%0d, required no beat", m_sidx, m_phase);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat %0d: got sidx=%0d phase=%0d sadv=%0d bid=%h first=%b last=%b, required sidx=%0d phase=%0d sadv=%0d bid=%h first=%b last=%b",
                   beats_seen, got.sidx, got.phase, got.sadv, got.bid, got.first, got.last,
                   exp.sidx, exp.phase, exp.sadv, exp.bid, exp.first, exp.last);
        end
      end
      beats_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int s, input int m);
    start = 1'b1;
    s_nbr = 12'(s);
    m_nbr = 12'(m);
    push_line(s, m);
    beats_seen = 0;
    tick();
    start = 1'b0;
    s_nbr = 12'($urandom);
    m_nbr = 12'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rnd, output bit to);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    to = (n >= budget);
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beats_seen < k && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", m_valid); end
    checks++;
    if ({m_first, m_last} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b%b, required 00", m_first, m_last);
    end
    checks++;
    if ({m_sidx, m_phase, m_sadv, m_bid} !== 36'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", {m_sidx, m_phase, m_sadv, m_bid});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b, required 0", busy); end
  endtask

  task automatic check_line(input string name, input int m);
    bit to;
    wait_idle(300, 1'b0, to);
    checks++;
    if (to !== 1'b0 || exp_q.size() != 0 || beats_seen != m) begin
      errors++;
      $display("FAIL %s_done: got timeout=%0b pending=%0d beats=%0d, required 0/0/%0d",
               name, to, exp_q.size(), beats_seen, m);
    end
  endtask

  task automatic test_upscale();
    int cyc;
    launch(4, 8);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: got %b, required 1", busy); end
    cyc = 0;
    while (!m_valid && cyc < 100) begin tick(); cyc++; end
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL up_latency: got %0d, required %0d", cyc, LAT); end
    check_line("up", 8);
  endtask

  task automatic test_downscale();
    launch(8, 4);
    check_line("down", 4);
  endtask

  task automatic test_unity();
    int n;
    launch(5, 5);
    check_line("unity", 5);
    launch(1, 1);
    n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    checks++;
    if ({m_valid, m_first, m_last} !== 3'b111) begin
      errors++; $display("FAIL single_flags: got v/f/l=%b%b%b, required 111", m_valid, m_first, m_last);
    end
    check_line("single", 1);
  endtask

  task automatic test_backpressure();
    beat_t got;
    launch(4, 8);
    wait_beats(2);
    checks++;
    if (m_valid !== 1'b1 || beats_seen != 2) begin
      errors++; $display("FAIL stall_entry: got valid=%b beats=%0d, required 1/2", m_valid, beats_seen);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {m_sidx, m_phase, m_sadv, m_bid, m_first, m_last};
      checks++;
      if (m_valid !== 1'b1 || exp_q.size() == 0 || got !== exp_q[0]) begin
        errors++;
        $display("FAIL stall_hold %0d: got valid=%b sidx=%0d phase=%0d sadv=%0d, required beat 2 held",
                 i, m_valid, m_sidx, m_phase, m_sadv);
      end
    end
    m_ready = 1'b1;
    check_line("stall", 8);
  endtask

  task automatic test_midline_reset();
    launch(3, 3);
    check_line("pre_reset", 3);
    launch(4, 8);
    wait_beats(3);
    m_ready = 1'b0;
    reset   = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, required 0", m_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    reset = 1'b0;
    exp_q.delete();
    tb_base = 0;
    m_ready = 1'b1;
    tick();
    launch(4, 8);
    check_line("after_reset", 8);
  endtask

  task automatic test_back_to_back();
    int n;
    launch(3, 3);
    wait_beats(1);
    start = 1'b1; s_nbr = 12'd9; m_nbr = 12'd2;
    tick();
    start = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || beats_seen != 3) begin
      errors++; $display("FAIL b2b_first: got busy=%b pending=%0d beats=%0d, required 0/0/3",
                         busy, exp_q.size(), beats_seen);
    end
    launch(3, 3);
    n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    checks++;
    if (m_bid[1:0] !== 2'd3) begin errors++; $display("FAIL b2b_bid0: got %0d, required 3", m_bid[1:0]); end
    wait_beats(2);
    // Start coincident with the final handshake must be dropped.
    start = 1'b1; s_nbr = 12'd2; m_nbr = 12'd2;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, m_valid} !== 2'b00 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_last_start: got busy=%b valid=%b pending=%0d, required 0/0/0",
                         busy, m_valid, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit to;
    int s, m;
    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(1, 20);
      m = $urandom_range(1, 20);
      launch(s, m);
      wait_idle(600, 1'b1, to);
      checks++;
      if (to !== 1'b0 || exp_q.size() != 0 || beats_seen != m) begin
        errors++;
        $display("FAIL rand_line s=%0d m=%0d: got timeout=%0b pending=%0d beats=%0d, required 0/0/%0d",
                 s, m, to, exp_q.size(), beats_seen, m);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b1;
    s_nbr   = '0;
    m_nbr   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_upscale();
    test_downscale();
    test_unity();
    test_backpressure();
    test_midline_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
